mrsc_decoder: RTL

Pipelined decoder for the 32-bit MRSC codeword (16 data + 16 redundancy bits) produced by the team's MRSC encoder. It recomputes diagonal, column-parity and row-check syndromes, corrects data bits whose three covering syndromes all fire, and classifies each word. It sits on the read path between protected storage and the consumer, with valid/ready handshakes on both sides and saturating error counters for status reporting.

---
 rtl/mrsc_pkg.sv | 77 +++++++
 rtl/mrsc_decoder_corrector.sv | 65 ++++++
 rtl/mrsc_decoder.sv | 105 ++++++++++
 3 files changed

// File: rtl/mrsc_pkg.sv
// mrsc_pkg: shared types, codeword bit positions and the syndrome function
// for the 32-bit MRSC codeword (16 data bits + 16 redundancy bits).
package mrsc_pkg;

   localparam int unsigned WORD_W   = 32;
   localparam int unsigned DATA_W   = 16;
   localparam int unsigned RED_W    = 16;
   localparam int unsigned SYN_W    = 16;
   localparam int unsigned DATA_LSB = 16;

   typedef enum logic [1:0] {
      MRSC_CLEAN         = 2'd0,
      MRSC_CORRECTED     = 2'd1,
      MRSC_CHECK_ERR     = 2'd2,
      MRSC_UNCORRECTABLE = 2'd3
   } mrsc_status_t;

   // Data bits: rows A..D, columns 1..4, A1 at the MSB.
   localparam int unsigned POS_A1 = 31;
   localparam int unsigned POS_A2 = 30;
   localparam int unsigned POS_A3 = 29;
   localparam int unsigned POS_A4 = 28;
   localparam int unsigned POS_B1 = 27;
   localparam int unsigned POS_B2 = 26;
   localparam int unsigned POS_B3 = 25;
   localparam int unsigned POS_B4 = 24;
   localparam int unsigned POS_C1 = 23;
   localparam int unsigned POS_C2 = 22;
   localparam int unsigned POS_C3 = 21;
   localparam int unsigned POS_C4 = 20;
   localparam int unsigned POS_D1 = 19;
   localparam int unsigned POS_D2 = 18;
   localparam int unsigned POS_D3 = 17;
   localparam int unsigned POS_D4 = 16;

   // Redundancy bits; the same positions index the 16-bit syndrome.
   localparam int unsigned POS_DI1  = 15;
   localparam int unsigned POS_DI3  = 14;
   localparam int unsigned POS_DI2  = 13;
   localparam int unsigned POS_DI4  = 12;
   localparam int unsigned POS_P1   = 11;
   localparam int unsigned POS_P3   = 10;
   localparam int unsigned POS_P2   = 9;
   localparam int unsigned POS_P4   = 8;
   localparam int unsigned POS_XA13 = 7;
   localparam int unsigned POS_XA24 = 6;
   localparam int unsigned POS_XB13 = 5;
   localparam int unsigned POS_XB24 = 4;
   localparam int unsigned POS_XC13 = 3;
   localparam int unsigned POS_XC24 = 2;
   localparam int unsigned POS_XD13 = 1;
   localparam int unsigned POS_XD24 = 0;

   // Recomputed redundancy XOR received redundancy, in redundancy bit order.
   function automatic logic [SYN_W-1:0] mrsc_syndrome(input logic [WORD_W-1:0] w);
      logic [SYN_W-1:0] calc;
      calc = '0;
      calc[POS_DI1]  = w[POS_A1] ^ w[POS_B2] ^ w[POS_C1] ^ w[POS_D2];
      calc[POS_DI2]  = w[POS_A2] ^ w[POS_B1] ^ w[POS_C2] ^ w[POS_D1];
      calc[POS_DI3]  = w[POS_A3] ^ w[POS_B4] ^ w[POS_C3] ^ w[POS_D4];
      calc[POS_DI4]  = w[POS_A4] ^ w[POS_B3] ^ w[POS_C4] ^ w[POS_D3];
      calc[POS_P1]   = w[POS_A1] ^ w[POS_B1] ^ w[POS_C1] ^ w[POS_D1];
      calc[POS_P2]   = w[POS_A2] ^ w[POS_B2] ^ w[POS_C2] ^ w[POS_D2];
      calc[POS_P3]   = w[POS_A3] ^ w[POS_B3] ^ w[POS_C3] ^ w[POS_D3];
      calc[POS_P4]   = w[POS_A4] ^ w[POS_B4] ^ w[POS_C4] ^ w[POS_D4];
      calc[POS_XA13] = w[POS_A1] ^ w[POS_A3];
      calc[POS_XA24] = w[POS_A2] ^ w[POS_A4];
      calc[POS_XB13] = w[POS_B1] ^ w[POS_B3];
      calc[POS_XB24] = w[POS_B2] ^ w[POS_B4];
      calc[POS_XC13] = w[POS_C1] ^ w[POS_C3];
      calc[POS_XC24] = w[POS_C2] ^ w[POS_C4];
      calc[POS_XD13] = w[POS_D1] ^ w[POS_D3];
      calc[POS_XD24] = w[POS_D2] ^ w[POS_D4];
      return calc ^ w[RED_W-1:0];
   endfunction

endpackage

// File: rtl/mrsc_decoder_corrector.sv
// mrsc_decoder_corrector: combinational correction and classification.
//   data     : received 16 data bits
//   syn      : 16-bit syndrome of the received word
//   red      : received 16 redundancy bits (for the residual check)
//   data_c   : corrected data, or received data when not CORRECTED
//   status_c : word classification
module mrsc_decoder_corrector
   import mrsc_pkg::*;
(
   input  logic [DATA_W-1:0] data,
   input  logic [SYN_W-1:0]  syn,
   input  logic [RED_W-1:0]  red,
   output logic [DATA_W-1:0] data_c,
   output mrsc_status_t      status_c
);

   logic [DATA_W-1:0] flip;
   logic [DATA_W-1:0] fixed;
   logic [SYN_W-1:0]  resid;
   logic              multi;

   // A data bit flips only when its column parity, row pair and diagonal all fire.
   always_comb begin
      flip = '0;
      flip[POS_A1-DATA_LSB] = syn[POS_P1] & syn[POS_XA13] & syn[POS_DI1];
      flip[POS_A2-DATA_LSB] = syn[POS_P2] & syn[POS_XA24] & syn[POS_DI2];
      flip[POS_A3-DATA_LSB] = syn[POS_P3] & syn[POS_XA13] & syn[POS_DI3];
      flip[POS_A4-DATA_LSB] = syn[POS_P4] & syn[POS_XA24] & syn[POS_DI4];
      flip[POS_B1-DATA_LSB] = syn[POS_P1] & syn[POS_XB13] & syn[POS_DI2];
      flip[POS_B2-DATA_LSB] = syn[POS_P2] & syn[POS_XB24] & syn[POS_DI1];
      flip[POS_B3-DATA_LSB] = syn[POS_P3] & syn[POS_XB13] & syn[POS_DI4];
      flip[POS_B4-DATA_LSB] = syn[POS_P4] & syn[POS_XB24] & syn[POS_DI3];
      flip[POS_C1-DATA_LSB] = syn[POS_P1] & syn[POS_XC13] & syn[POS_DI1];
      flip[POS_C2-DATA_LSB] = syn[POS_P2] & syn[POS_XC24] & syn[POS_DI2];
      flip[POS_C3-DATA_LSB] = syn[POS_P3] & syn[POS_XC13] & syn[POS_DI3];
      flip[POS_C4-DATA_LSB] = syn[POS_P4] & syn[POS_XC24] & syn[POS_DI4];
      flip[POS_D1-DATA_LSB] = syn[POS_P1] & syn[POS_XD13] & syn[POS_DI2];
      flip[POS_D2-DATA_LSB] = syn[POS_P2] & syn[POS_XD24] & syn[POS_DI1];
      flip[POS_D3-DATA_LSB] = syn[POS_P3] & syn[POS_XD13] & syn[POS_DI4];
      flip[POS_D4-DATA_LSB] = syn[POS_P4] & syn[POS_XD24] & syn[POS_DI3];
   end

   assign fixed = data ^ flip;
   // Correction is trusted only if it fully explains the syndrome.
   assign resid = mrsc_syndrome({fixed, red});
   // More than one syndrome bit set.
   assign multi = |(syn & (syn - SYN_W'(1)));

   // Classification; received data passes through unless the fix is confirmed.
   always_comb begin
      data_c   = data;
      status_c = MRSC_UNCORRECTABLE;
      if (syn == '0) begin
         status_c = MRSC_CLEAN;
      end else if (flip != '0) begin
         if (resid == '0) begin
            data_c   = fixed;
            status_c = MRSC_CORRECTED;
         end
      end else if (!multi) begin
         status_c = MRSC_CHECK_ERR;
      end
   end

endmodule

// File: rtl/mrsc_decoder.sv
// mrsc_decoder: two-stage pipelined MRSC decoder with valid/ready handshakes.
//   clk, rst_n         : clock, asynchronous active-low reset
//   in_valid/in_ready  : input handshake, in_word is the received codeword
//   out_valid/out_ready: output handshake, out_data/out_status the result
//   cnt_clear          : synchronous clear of both counters
//   corr_count         : saturating count of CORRECTED or CHECK_ERR words
//   uncorr_count       : saturating count of UNCORRECTABLE words
module mrsc_decoder
   import mrsc_pkg::*;
#(
   parameter int unsigned CNT_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WORD_W-1:0] in_word,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output mrsc_status_t      out_status,
   input  logic              cnt_clear,
   output logic [CNT_W-1:0]  corr_count,
   output logic [CNT_W-1:0]  uncorr_count
);

   logic              s1_valid;
   logic [DATA_W-1:0] s1_data;
   logic [SYN_W-1:0]  s1_syn;
   logic [RED_W-1:0]  s1_red;

   logic              adv_out;
   logic              adv_s1;
   logic              xfer;
   logic [DATA_W-1:0] fix_data_c;
   mrsc_status_t      fix_status_c;

   // Each stage advances when it is empty or the stage ahead moves.
   assign adv_out  = !out_valid || out_ready;
   assign adv_s1   = !s1_valid || adv_out;
   assign in_ready = adv_s1;
   assign xfer     = out_valid && out_ready;

   // Stage 1: capture data, redundancy and syndrome.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
         s1_syn   <= '0;
         s1_red   <= '0;
      end else if (adv_s1) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_data <= in_word[WORD_W-1:RED_W];
            s1_syn  <= mrsc_syndrome(in_word);
            s1_red  <= in_word[RED_W-1:0];
         end
      end
   end

   mrsc_decoder_corrector u_corrector (
      .data     (s1_data),
      .syn      (s1_syn),
      .red      (s1_red),
      .data_c   (fix_data_c),
      .status_c (fix_status_c)
   );

   // Stage 2: output register, held while the consumer stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_status <= MRSC_CLEAN;
      end else if (adv_out) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_data   <= fix_data_c;
            out_status <= fix_status_c;
         end
      end
   end

   // Status counters count on output transfer; clear wins over increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         corr_count   <= '0;
         uncorr_count <= '0;
      end else if (cnt_clear) begin
         corr_count   <= '0;
         uncorr_count <= '0;
      end else if (xfer) begin
         if (out_status == MRSC_CORRECTED || out_status == MRSC_CHECK_ERR) begin
            if (corr_count != '1) begin
               corr_count <= corr_count + CNT_W'(1);
            end
         end else if (out_status == MRSC_UNCORRECTABLE) begin
            if (uncorr_count != '1) begin
               uncorr_count <= uncorr_count + CNT_W'(1);
            end
         end
      end
   end

endmodule
